return_address_stack: RTL and testbench
=======================================

# return_address_stack

Predicts return targets for RISC-V call/return jumps. On each executed JAL/JALR, the block decodes the link-register hints on rd/rs1 and decides whether to push the return address (PC+4), pop a return prediction, or both. Pops return the predicted JALR target to the fetch stage. The block sits beside the JALR target adder: the adder produces the architectural target, and this block supplies the early prediction that the adder later confirms or corrects.

## Interface
Parameters:
- NBits, 32, address/data width
- DEPTH, 8, stack entries; must be a power of 2 and at least 2

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears the stack
- Enable_i  input  1  instruction valid and not stalled; all updates are qualified by it
- Jal_i  input  1  current instruction is JAL
- Jalr_i  input  1  current instruction is JALR
- Rd_i  input  5  destination register index
- Rs1_i  input  5  source register index
- Return_Addr_i  input  NBits  PC+4 of the current instruction
- Predicted_Target_o  output  NBits  top-of-stack value before this cycle's update; 0 when empty
- Predict_Valid_o  output  1  pop requested this cycle and stack not empty
- Count_o  output  $clog2(DEPTH)+1  valid entries, 0..DEPTH
- Full_o  output  1  Count_o == DEPTH
- Empty_o  output  1  Count_o == 0
- Underflow_o  output  1  one-cycle pulse: pop requested while empty
- Overflow_o  output  1  one-cycle pulse: push while full overwrote the oldest entry

## Operation
- A register is a link register when its index is 1 or 5.
- Hint decode is combinational and gated by Enable_i:
  - JAL with rd a link register: push.
  - JAL with rd not a link register: no action.
  - JALR, rd not link, rs1 not link: no action.
  - JALR, rd not link, rs1 link: pop.
  - JALR, rd link, rs1 not link: push.
  - JALR, rd link, rs1 link, rd != rs1: pop-then-push (replace the top).
  - JALR, rd link, rs1 link, rd == rs1: push.
- Jal_i and Jalr_i both high is illegal; JAL takes priority.
- Storage is a circular buffer of DEPTH entries with a top pointer (tos) of $clog2(DEPTH) bits. The pointer wraps modulo DEPTH.
- Push:
  - tos advances by 1, and mem[tos+1] is written with Return_Addr_i.
  - Count increments, saturating at DEPTH.
  - If the stack was full, the oldest entry is lost and Overflow_o pulses.
- Pop:
  - If not empty, tos decrements by 1 and Count decrements.
  - If empty, the state is unchanged, Underflow_o pulses, and Predict_Valid_o is 0.
- Pop-then-push:
  - If not empty, mem[tos] is overwritten with Return_Addr_i; tos and Count are unchanged; Predict_Valid_o is 1.
  - If empty, it behaves as a plain push, and Underflow_o pulses.
- Predicted_Target_o = mem[tos] when not empty, otherwise 0. It is driven combinationally from current state, independent of the pop request.

## Timing
- Predicted_Target_o, Predict_Valid_o, Full_o, Empty_o and Count_o are combinational from the registered state; there is zero-cycle prediction latency.
- Stack updates take effect at the next rising clk edge. A push in cycle N is visible on Predicted_Target_o in cycle N+1.
- Underflow_o and Overflow_o are registered pulses, asserted in cycle N+1 for one cycle.
- Reset at any time, including mid-sequence, sets the following on the next edge:
  - tos = 0 and Count = 0.
  - Both pulse outputs = 0.
  - Resulting outputs: Empty_o = 1, Full_o = 0, Predicted_Target_o = 0.
- Memory contents need not be cleared. Reset has priority over any update in the same cycle.
- With Enable_i = 0, state holds and no pulses are generated.

## Structure
- Shared package holds:
  - LINK_X1 = 5'd1 and LINK_X5 = 5'd5.
  - An encoded action type: RAS_NONE, RAS_PUSH, RAS_POP, RAS_POP_PUSH.
- Sub-module ras_hint_decode is purely combinational. It takes Jal_i, Jalr_i, Rd_i, Rs1_i and Enable_i, and outputs the action.
- The top level contains the pointer/count registers, the DEPTH x NBits register array and the pulse flops.

## Test plan
- Reset, then JAL rd=1, Return_Addr=0x104 → next cycle: Count_o=1, Predicted_Target_o=0x104, Empty_o=0.
- Nested calls: JAL rd=1 at 0x104, then at 0x208. Then JALR rd=0 rs1=1, twice → first pop: Predict_Valid_o=1, target 0x208. Second pop: target 0x104. Afterwards Empty_o=1.
- Overflow: DEPTH+1=9 pushes of 0x10, 0x20, …, 0x90 → Overflow_o pulses once after the ninth push; Count_o=8. Eight pops return 0x90 down to 0x20; a ninth pop gives Underflow_o and Predict_Valid_o=0.
- Replace: push 0x300, then JALR rd=5 rs1=1 with Return_Addr=0x404 → Predict_Valid_o=1, target 0x300 in that cycle; next cycle target 0x404 and Count_o unchanged at 1. Repeat with rd=1 rs1=1 → plain push, Count_o=2.
- Gating and non-link: Enable_i=0 with a JAL rd=1 → no change. JAL rd=0 and JALR rd=2 rs1=3 → no change, no pulses.
- Reset mid-stream: with 3 entries, assert reset together with a push → next cycle Count_o=0, Empty_o=1, Predicted_Target_o=0, no Overflow_o.

Source files
------------

// File: rtl/return_address_stack_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | return_address_stack_pkg: link-register constants, RAS action type |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package return_address_stack_pkg;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic [1:0] {
    RAS_NONE     = 2'd0,
    RAS_PUSH     = 2'd1,
    RAS_POP      = 2'd2,
    RAS_POP_PUSH = 2'd3
  } ras_action_e;

  function automatic logic is_link(input logic [4:0] reg_idx);
    return (reg_idx == LINK_X1) || (reg_idx == LINK_X5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/return_address_stack_hint_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ras_hint_decode: maps JAL/JALR rd/rs1 hints onto a stack action    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ras_hint_decode
  import return_address_stack_pkg::*;
(
  input  logic        Enable_i,
  input  logic        Jal_i,
  input  logic        Jalr_i,
  input  logic [4:0]  Rd_i,
  input  logic [4:0]  Rs1_i,
  output ras_action_e Action_o
);

  logic w_rd_link;
  logic w_rs1_link;

  assign w_rd_link  = is_link(Rd_i);
  assign w_rs1_link = is_link(Rs1_i);

  always_comb begin
    Action_o = RAS_NONE;
    if (Enable_i) begin
      // JAL wins if both instruction flags are raised
      if (Jal_i) begin
        if (w_rd_link) Action_o = RAS_PUSH;
      end else if (Jalr_i) begin
        case ({w_rd_link, w_rs1_link})
          2'b01:   Action_o = RAS_POP;
          2'b10:   Action_o = RAS_PUSH;
          2'b11:   Action_o = (Rd_i == Rs1_i) ? RAS_PUSH : RAS_POP_PUSH;
          default: Action_o = RAS_NONE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/return_address_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | return_address_stack: circular return-address predictor stack      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int NBits = 32,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Enable_i,
  input  logic                    Jal_i,
  input  logic                    Jalr_i,
  input  logic [4:0]              Rd_i,
  input  logic [4:0]              Rs1_i,
  input  logic [NBits-1:0]        Return_Addr_i,
  output logic [NBits-1:0]        Predicted_Target_o,
  output logic                    Predict_Valid_o,
  output logic [$clog2(DEPTH):0]  Count_o,
  output logic                    Full_o,
  output logic                    Empty_o,
  output logic                    Underflow_o,
  output logic                    Overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  ras_action_e            w_action;
  logic [PTR_W-1:0]       r_tos;
  logic [CNT_W-1:0]       r_count;
  logic [NBits-1:0]       r_mem [DEPTH];
  logic                   r_underflow;
  logic                   r_overflow;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop_req;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_replace;
  logic [PTR_W-1:0]       w_tos_inc;

  ras_hint_decode u_hint_decode (
    .Enable_i (Enable_i),
    .Jal_i    (Jal_i),
    .Jalr_i   (Jalr_i),
    .Rd_i     (Rd_i),
    .Rs1_i    (Rs1_i),
    .Action_o (w_action)
  );

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);
  assign w_pop_req = (w_action == RAS_POP) || (w_action == RAS_POP_PUSH);
  // A pop-then-push on an empty stack degrades to a plain push
  assign w_push    = (w_action == RAS_PUSH) || ((w_action == RAS_POP_PUSH) && w_empty);
  assign w_pop     = (w_action == RAS_POP) && !w_empty;
  assign w_replace = (w_action == RAS_POP_PUSH) && !w_empty;
  assign w_tos_inc = r_tos + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tos       <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_underflow <= w_pop_req && w_empty;
      r_overflow  <= w_push && w_full;
      if (w_push) begin
        r_tos <= w_tos_inc;
        if (!w_full) r_count <= r_count + CNT_W'(1);
      end else if (w_pop) begin
        r_tos   <= r_tos - PTR_W'(1);
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Storage carries no reset; Empty_o masks stale contents
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_push)         r_mem[w_tos_inc] <= Return_Addr_i;
      else if (w_replace) r_mem[r_tos]     <= Return_Addr_i;
    end
  end

  assign Predicted_Target_o = w_empty ? '0 : r_mem[r_tos];
  assign Predict_Valid_o    = w_pop_req && !w_empty;
  assign Count_o            = r_count;
  assign Full_o             = w_full;
  assign Empty_o            = w_empty;
  assign Underflow_o        = r_underflow;
  assign Overflow_o         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_return_address_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_return_address_stack: directed scoreboard bench for the RAS     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_return_address_stack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        jal = 1'b0;
  logic        jalr = 1'b0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [31:0] ra = '0;
  logic [31:0] tgt;
  logic        pv;
  logic [3:0]  cnt;
  logic        full;
  logic        empty;
  logic        uf;
  logic        of;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        pv;
    logic [31:0] tgt;
    logic [3:0]  cnt;
    logic        uf;
    logic        of;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  return_address_stack #(.NBits(32), .DEPTH(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .Enable_i           (en),
    .Jal_i              (jal),
    .Jalr_i             (jalr),
    .Rd_i               (rd),
    .Rs1_i              (rs1),
    .Return_Addr_i      (ra),
    .Predicted_Target_o (tgt),
    .Predict_Valid_o    (pv),
    .Count_o            (cnt),
    .Full_o             (full),
    .Empty_o            (empty),
    .Underflow_o        (uf),
    .Overflow_o         (of)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("predict_valid", 32'(pv), 32'(e.pv));
      chk("target", tgt, e.tgt);
      chk("count", 32'(cnt), 32'(e.cnt));
      chk("empty", 32'(empty), 32'(e.cnt == 4'd0));
      chk("full", 32'(full), 32'(e.cnt == 4'd8));
      chk("underflow", 32'(uf), 32'(e.uf));
      chk("overflow", 32'(of), 32'(e.of));
    end
  end

  // Apply one cycle of stimulus; expectations describe outputs in that same cycle
  task automatic step(input logic c, input logic rst, input logic en_v, input logic jal_v,
                      input logic jalr_v, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                      input logic [31:0] ra_v, input logic pv_e, input logic [31:0] tgt_e,
                      input logic [3:0] cnt_e, input logic uf_e, input logic of_e);
    exp_t x;
    @(posedge clk);
    #1;
    reset = rst; en = en_v; jal = jal_v; jalr = jalr_v;
    rd = rd_v; rs1 = rs1_v; ra = ra_v;
    if (c) begin
      x.pv = pv_e; x.tgt = tgt_e; x.cnt = cnt_e; x.uf = uf_e; x.of = of_e;
      exp_q.push_back(x);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    // single call, then nested call and two returns
    step(1, 0, 1, 1, 0, 5'd1, 0, 32'h104, 0, 32'h0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 5'd1, 0, 32'h208, 0, 32'h104, 1, 0, 0);
    step(1, 0, 1, 0, 1, 5'd0, 5'd1, 32'h999, 1, 32'h208, 2, 0, 0);
    step(1, 0, 1, 0, 1, 5'd0, 5'd1, 32'h999, 1, 32'h104, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    // nine pushes overflow an eight-entry stack
    for (int i = 1; i <= 9; i++)
      step(1, 0, 1, 1, 0, 5'd5, 0, 32'(i * 16), 0, (i == 1) ? 32'h0 : 32'((i - 1) * 16),
           (i == 9) ? 4'd8 : 4'(i - 1), 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h90, 8, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h90, 8, 0, 0);
    for (int j = 0; j < 8; j++)
      step(1, 0, 1, 0, 1, 5'd0, 5'd5, 0, 1, 32'(144 - 16 * j), 4'(8 - j), 0, 0);
    step(1, 0, 1, 0, 1, 5'd0, 5'd5, 0, 0, 32'h0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
    // replace top, then rd==rs1 acts as push
    step(1, 0, 1, 1, 0, 5'd5, 0, 32'h300, 0, 32'h0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 5'd5, 5'd1, 32'h404, 1, 32'h300, 1, 0, 0);
    step(1, 0, 1, 0, 1, 5'd1, 5'd1, 32'h408, 0, 32'h404, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h408, 2, 0, 0);
    // gated and non-link instructions leave state untouched
    step(1, 0, 0, 1, 0, 5'd1, 0, 32'h500, 0, 32'h408, 2, 0, 0);
    step(1, 0, 1, 1, 0, 5'd0, 0, 32'h600, 0, 32'h408, 2, 0, 0);
    step(1, 0, 1, 0, 1, 5'd2, 5'd3, 32'h650, 0, 32'h408, 2, 0, 0);
    step(1, 0, 0, 0, 1, 5'd0, 5'd1, 32'h660, 0, 32'h408, 2, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h408, 2, 0, 0);
    // three entries, then reset coincident with a push
    step(1, 0, 1, 1, 0, 5'd1, 0, 32'h700, 0, 32'h408, 2, 0, 0);
    step(1, 1, 1, 1, 0, 5'd1, 0, 32'h800, 0, 32'h700, 3, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    // pop-then-push on empty: plain push plus underflow
    step(1, 0, 1, 0, 1, 5'd1, 5'd5, 32'hA00, 0, 32'h0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA00, 1, 1, 0);
    // JAL priority over JALR
    step(1, 0, 1, 1, 1, 5'd0, 5'd1, 32'hB00, 0, 32'hA00, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA00, 1, 0, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
